// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the unified memory port.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              dm_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              grant_dm;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, grant_dm
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, grant_dm
  );
endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter with zero flag for fixed-latency waits.
module mem_lat_counter #(
  parameter  int MEM_LAT = 2,
  localparam int W = $clog2(MEM_LAT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst) cnt <= '0;
    else if (load) cnt <= loadVal;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and MEM stages, data first.
// Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_e state;
  logic memEn, memWe, ifReady, dmReady, grantDm, cntZero, arbGo, starveHit, pickDm;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata, ifRdata, dmRdata;
  logic [SW-1:0] starveCnt;
  assign arbGo     = state == ST_IDLE && (bus.dm_req || bus.if_req);
  assign starveHit = bus.if_req && starveCnt == SW'(STARVE_MAX);
  assign pickDm    = bus.dm_req && !starveHit;
  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (arbGo),
    .loadVal (CW'(MEM_LAT - 1)),
    .dec     (state == ST_ACCESS),
    .zero    (cntZero)
  );
`ifdef ARB_STARVE_GUARD_EN
  // Counts data grants that made a waiting fetch lose arbitration.
  always_ff @(posedge clk)
    if (!rst) starveCnt <= '0;
    else if (arbGo) starveCnt <= pickDm && bus.if_req ? starveCnt + 1'b1 : '0;
`else
  assign starveCnt = '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      memEn    <= 1'b0;
      memWe    <= 1'b0;
      ifReady  <= 1'b0;
      dmReady  <= 1'b0;
      grantDm  <= GNT_IF;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dmRdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (arbGo) begin
          state    <= ST_ACCESS;
          memEn    <= 1'b1;
          grantDm  <= pickDm ? GNT_DM : GNT_IF;
          memAddr  <= pickDm ? bus.dm_addr : bus.if_addr;
          memWe    <= pickDm && bus.dm_we;
          memWdata <= pickDm ? bus.dm_wdata : memWdata;
        end
        ST_ACCESS: if (cntZero) begin
          state   <= ST_RESP;
          memEn   <= 1'b0;
          memWe   <= 1'b0;
          ifReady <= grantDm == GNT_IF;
          dmReady <= grantDm == GNT_DM;
          dmRdata <= !memWe && grantDm == GNT_DM ? bus.mem_rdata : dmRdata;
          ifRdata <= !memWe && grantDm == GNT_IF ? bus.mem_rdata : ifRdata;
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          ifReady <= 1'b0;
          dmReady <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_rdata  = ifRdata;
  assign bus.dm_rdata  = dmRdata;
  assign bus.if_ready  = ifReady;
  assign bus.dm_ready  = dmReady;
  assign bus.grant_dm  = grantDm;
  assign bus.if_stall  = bus.if_req && !ifReady;
  assign bus.dm_stall  = bus.dm_req && !dmReady;
endmodule
